// File: rtl/whack_pkg.sv
// whack_pkg -- definitions shared by the image blitter files.
//   SCREEN_W_DEF / SCREEN_H_DEF : visible VGA adapter area (columns / rows)
//   COLOUR_BITS_DEF             : colour word width, 4 bits per channel
//   blit_state_t                : blitter sequencing states
package whack_pkg;

  localparam int SCREEN_W_DEF    = 160;
  localparam int SCREEN_H_DEF    = 120;
  localparam int COLOUR_BITS_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } blit_state_t;

endpackage

// File: rtl/pixel_delay_line.sv
// pixel_delay_line -- fixed-depth shift register that carries the
// (valid, payload) of each issued ROM address so it lines up with rom_q.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_valid/i_data : tag of the address issued this cycle
//   o_valid/o_data : same tag, DEPTH cycles later
module pixel_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [W-1:0]     r_data [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/image_blitter.sv
// image_blitter -- copies one image from a selectable ROM to the VGA adapter,
// one pixel per clock, clipping pixels that fall off screen.
//   clk, reset         : clock, synchronous active-high reset
//   start/src_sel/x0/y0: draw request, ROM index and screen origin
//   rom_addr / rom_q   : shared ROM address, concatenated ROM outputs
//   x, y, colour, plot : pixel write to the VGA adapter
//   busy, done         : draw in progress / one-cycle end-of-image pulse
// Build option: IMAGE_BLITTER_TRANSPARENT_KEY_EN adds KEY_COLOUR; pixels of
// that colour are not plotted.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | issuing one ROM address per cycle, row-major
// DRAIN  | ROM_LATENCY cycles for the last pixels to come out of the ROM
// FINISH | done pulse, back to IDLE
module image_blitter
  import whack_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int COLOUR_BITS = COLOUR_BITS_DEF,
  parameter int NUM_SRC     = 2,
  parameter int ROM_LATENCY = 1,
  parameter int ADDR_W      = 15,
  parameter int COORD_W     = 8
`ifdef IMAGE_BLITTER_TRANSPARENT_KEY_EN
  ,
  parameter logic [COLOUR_BITS-1:0] KEY_COLOUR = 12'hF0F
`endif
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] src_sel,
  input  logic [COORD_W-1:0]                               x0,
  input  logic [COORD_W-1:0]                               y0,
  output logic [ADDR_W-1:0]                                rom_addr,
  input  logic [NUM_SRC*COLOUR_BITS-1:0]                   rom_q,
  output logic [COORD_W-1:0]                               x,
  output logic [COORD_W-1:0]                               y,
  output logic [COLOUR_BITS-1:0]                           colour,
  output logic                                             plot,
  output logic                                             busy,
  output logic                                             done
);

  localparam int                 SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [COORD_W-1:0] LAST_COL   = COORD_W'(IMG_W - 1);
  localparam logic [2:0]         DRAIN_LOAD = 3'(ROM_LATENCY - 1);

  blit_state_t        r_state, w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [COORD_W-1:0] r_col, r_row, r_x0, r_y0;
  logic [SEL_W-1:0]   r_sel;
  logic [2:0]         r_drain;
  logic               w_issue, w_last_issue, w_accept;
  logic               w_busy, w_done;

  assign w_accept     = (r_state == ST_IDLE) && start;
  assign w_issue      = (r_state == ST_RUN);
  assign w_last_issue = w_issue && (r_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start)        w_next = ST_RUN;
      ST_RUN:    if (w_last_issue) w_next = ST_DRAIN;
      ST_DRAIN:  if (r_drain == '0) w_next = ST_FINISH;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_RUN, ST_DRAIN: w_busy = 1'b1;
      ST_FINISH:        w_done = 1'b1;
      default:          ;
    endcase
  end

  // Address, raster counters and drain timer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_sel   <= '0;
      r_drain <= '0;
    end else if (w_accept) begin
      r_sel  <= src_sel;
      r_x0   <= x0;
      r_y0   <= y0;
      r_addr <= '0;
      r_col  <= '0;
      r_row  <= '0;
    end else if (w_issue) begin
      if (w_last_issue) begin
        r_drain <= DRAIN_LOAD;
      end else begin
        r_addr <= r_addr + ADDR_W'(1);
        if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= r_row + COORD_W'(1);
        end else begin
          r_col <= r_col + COORD_W'(1);
        end
      end
    end else if (r_state == ST_DRAIN && r_drain != '0) begin
      r_drain <= r_drain - 3'd1;
    end
  end

  logic                   w_al_valid;
  logic [COORD_W-1:0]     w_al_col, w_al_row;
  logic [COORD_W:0]       w_xs, w_ys;
  logic [COLOUR_BITS-1:0] w_pix;
  logic                   w_on_screen, w_key_hit;

  pixel_delay_line #(
    .DEPTH (ROM_LATENCY),
    .W     (2 * COORD_W)
  ) u_delay (
    .i_clk   (clk),
    .i_reset (reset),
    .i_valid (w_issue),
    .i_data  ({r_col, r_row}),
    .o_valid (w_al_valid),
    .o_data  ({w_al_col, w_al_row})
  );

  // One extra bit so an origin near the edge clips instead of wrapping.
  assign w_xs  = {1'b0, r_x0} + {1'b0, w_al_col};
  assign w_ys  = {1'b0, r_y0} + {1'b0, w_al_row};
  assign w_pix = rom_q[r_sel*COLOUR_BITS +: COLOUR_BITS];
  assign w_on_screen = (w_xs < (COORD_W+1)'(SCREEN_W)) && (w_ys < (COORD_W+1)'(SCREEN_H));

`ifdef IMAGE_BLITTER_TRANSPARENT_KEY_EN
  assign w_key_hit = (w_pix == KEY_COLOUR);
`else
  assign w_key_hit = 1'b0;
`endif

  assign plot     = w_al_valid && w_on_screen && !w_key_hit;
  assign colour   = w_al_valid ? w_pix : '0;
  assign x        = w_al_valid ? w_xs[COORD_W-1:0] : '0;
  assign y        = w_al_valid ? w_ys[COORD_W-1:0] : '0;
  assign rom_addr = r_addr;
  assign busy     = w_busy;
  assign done     = w_done;

endmodule
